// File: rtl/fetch_pkg.sv
// Shared defaults and the IF/ID packet type for the fetch stage.
//   DEF_WIDTH    instruction width (matches inst_mem width)
//   DEF_ADR_IN   PC / read address width (matches inst_mem adr_in)
//   DEF_RESET_PC PC loaded on reset
//   DEF_PC_STEP  PC increment per fetch (inst_mem is word indexed)
package fetch_pkg;

    localparam int unsigned     DEF_WIDTH    = 32;
    localparam int unsigned     DEF_ADR_IN   = 64;
    localparam longint unsigned DEF_RESET_PC = 64'd0;
    localparam longint unsigned DEF_PC_STEP  = 64'd1;

    typedef struct packed {
        logic [DEF_ADR_IN-1:0] pc;
        logic [DEF_WIDTH-1:0]  instr;
    } fetch_pkt_t;

endpackage

// File: rtl/if_id_reg.sv
// One-entry valid/ready pipeline register between fetch and decode.
// Ports:
//   clk, rst  rising-edge clock, synchronous active-high reset
//   flush     drop the held packet (highest priority)
//   load      capture in_pkt and mark the slot valid
//   ready     downstream accepts the slot this cycle
//   in_pkt    packet to capture on load
//   valid     slot holds a packet
//   out_pkt   held packet
module if_id_reg
    import fetch_pkg::*;
#(
    parameter type pkt_t = fetch_pkt_t
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic load,
    input  logic ready,
    input  pkt_t in_pkt,
    output logic valid,
    output pkt_t out_pkt
);

    logic valid_q, valid_d;
    pkt_t pkt_q, pkt_d;

    always_comb begin
        valid_d = valid_q;
        pkt_d   = pkt_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            pkt_d   = in_pkt;
        end else if (valid_q && ready) begin
            // Drained with nothing new to replace it.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pkt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pkt_q   <= pkt_d;
        end
    end

    assign valid   = valid_q;
    assign out_pkt = pkt_q;

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, addresses inst_mem combinationally and feeds the
// IF/ID register, handling decode back-pressure, redirects and halt.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   read_adr        address to inst_mem (always equals pc)
//   instruction     inst_mem data for read_adr, same cycle
//   redirect_valid  redirect request from execute
//   redirect_pc     redirect target
//   out_valid       IF/ID slot holds an instruction
//   out_ready       decode accepts the slot this cycle
//   out_instr       fetched instruction
//   out_pc          address of out_instr
//   halted          pc >= DEPTH, fetch suspended
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned     WIDTH    = DEF_WIDTH,
    parameter int unsigned     DEPTH    = 80,
    parameter int unsigned     ADR_IN   = DEF_ADR_IN,
    parameter longint unsigned RESET_PC = DEF_RESET_PC,
    parameter longint unsigned PC_STEP  = DEF_PC_STEP
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADR_IN-1:0] read_adr,
    input  logic [WIDTH-1:0]  instruction,
    input  logic              redirect_valid,
    input  logic [ADR_IN-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_instr,
    output logic [ADR_IN-1:0] out_pc,
    output logic              halted
);

    localparam logic [ADR_IN-1:0] PC_RESET = ADR_IN'(RESET_PC);
    localparam logic [ADR_IN-1:0] PC_INC   = ADR_IN'(PC_STEP);
    localparam logic [ADR_IN-1:0] PC_DEPTH = ADR_IN'(DEPTH);

    // Packet sized by this instance's parameters.
    typedef struct packed {
        logic [ADR_IN-1:0] pc;
        logic [WIDTH-1:0]  instr;
    } pkt_t;

    logic [ADR_IN-1:0] pc_q, pc_d;
    logic              space;
    logic              fetch;
    pkt_t              in_pkt;
    pkt_t              out_pkt;

    assign halted = (pc_q >= PC_DEPTH);
    assign space  = !out_valid || out_ready;
    assign fetch  = space && !halted && !redirect_valid;

    // Redirect beats fetch; otherwise pc only moves when a fetch is loaded.
    // Wraps modulo 2^ADR_IN, though halt stops it long before.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (fetch) begin
            pc_d = pc_q + PC_INC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign read_adr     = pc_q;
    assign in_pkt.pc    = pc_q;
    assign in_pkt.instr = instruction;

    // A redirect flushes the slot even under stall; take without a new
    // fetch empties it inside the register.
    if_id_reg #(
        .pkt_t (pkt_t)
    ) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .flush   (redirect_valid),
        .load    (fetch),
        .ready   (out_ready),
        .in_pkt  (in_pkt),
        .valid   (out_valid),
        .out_pkt (out_pkt)
    );

    assign out_pc    = out_pkt.pc;
    assign out_instr = out_pkt.instr;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    localparam int unsigned W = 32;
    localparam int unsigned A = 64;
    localparam int unsigned D = 80;

    logic         clk = 1'b0;
    logic         rst;
    logic [A-1:0] read_adr;
    logic [W-1:0] instruction;
    logic         redirect_valid;
    logic [A-1:0] redirect_pc;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_instr;
    logic [A-1:0] out_pc;
    logic         halted;

    int total = 0;
    int bad   = 0;

    // Expected (pc) of every slot decode accepts, in order; instr == pc.
    logic [A-1:0] exp_q[$];

    always #5 clk = ~clk;

    // inst_mem model: memory[a] = a, combinational read.
    assign instruction = (read_adr < 64'(D)) ? read_adr[W-1:0] : 32'hdead_beef;

    inst_fetch #(
        .WIDTH    (W),
        .DEPTH    (D),
        .ADR_IN   (A),
        .RESET_PC (64'd0),
        .PC_STEP  (64'd1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .read_adr       (read_adr),
        .instruction    (instruction),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) exp_q.push_back(64'(i));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a slot is consumed at the coming edge when valid & ready & !rst.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_take_pc", out_pc, 64'hffff_ffff_ffff_ffff);
            end else begin
                logic [A-1:0] e;
                e = exp_q.pop_front();
                check("take_pc", out_pc, e);
                check("take_instr", 64'(out_instr), 64'(e[W-1:0]));
            end
        end
    end

    initial begin
        bit got;
        rst            = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // 1. reset for two edges, then stream from 0
        tick();
        tick();
        rst = 1'b0;
        push_range(0, 2);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_read_adr", read_adr, 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        tick();
        @(negedge clk);
        check("first_valid", 64'(out_valid), 64'd1);
        check("first_pc", out_pc, 64'd0);
        tick();
        tick();

        // 3. redirect to 7 while out_pc=2 (slot 2 is taken, then flushed)
        redirect_valid = 1'b1;
        redirect_pc    = 64'd7;
        push_range(7, 79);
        @(negedge clk);
        check("redir_at_pc", out_pc, 64'd2);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_bubble_valid", 64'(out_valid), 64'd0);
        check("redir_read_adr", read_adr, 64'd7);
        tick();
        @(negedge clk);
        check("redir_target_valid", 64'(out_valid), 64'd1);
        check("redir_target_pc", out_pc, 64'd7);
        check("redir_target_instr", 64'(out_instr), 64'd7);
        tick();
        tick();

        // 2. stall for 4 edges while out_instr=9
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_instr", 64'(out_instr), 64'd9);
            check("stall_read_adr", read_adr, 64'd10);
            check("stall_valid", 64'(out_valid), 64'd1);
            tick();
        end
        out_ready = 1'b1;

        // 4. free-run to the end of memory
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (halted) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check("halt_reached", 64'(got), 64'd1);
        check("halt_last_pc", out_pc, 64'd79);
        check("halt_read_adr", read_adr, 64'd80);
        tick();
        @(negedge clk);
        check("halt_drained_valid", 64'(out_valid), 64'd0);
        check("halt_still", 64'(halted), 64'd1);
        check("halt_read_adr_hold", read_adr, 64'd80);
        tick();
        @(negedge clk);
        check("halt_no_fetch", 64'(out_valid), 64'd0);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'd5;
        push_range(5, 5);
        @(negedge clk);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("resume_halted", 64'(halted), 64'd0);
        check("resume_read_adr", read_adr, 64'd5);
        check("resume_valid", 64'(out_valid), 64'd0);
        tick();
        @(negedge clk);
        check("resume_pc", out_pc, 64'd5);
        tick();

        // 5. redirect to 10 under stall with out_pc=6: 6 never accepted
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'd10;
        push_range(10, 19);
        @(negedge clk);
        check("stall_redir_pc", out_pc, 64'd6);
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        @(negedge clk);
        check("stall_redir_bubble", 64'(out_valid), 64'd0);
        tick();
        @(negedge clk);
        check("stall_redir_target", out_pc, 64'd10);

        // 6. reset mid-stream at out_pc=20
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid && out_pc == 64'd19) begin
                got = 1'b1;
                break;
            end
            tick();
            @(negedge clk);
        end
        check("reach_pc19", 64'(got), 64'd1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_pc", out_pc, 64'd20);
        tick();
        rst = 1'b0;
        push_range(0, 5);
        @(negedge clk);
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_read_adr", read_adr, 64'd0);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) begin
                got = 1'b1;
                break;
            end
        end
        check("restart_drained", 64'(got), 64'd1);

        // redirect beyond memory halts immediately
        tick();
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'd100;
        @(negedge clk);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("far_halted", 64'(halted), 64'd1);
        check("far_read_adr", read_adr, 64'd100);
        check("far_valid", 64'(out_valid), 64'd0);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
